// File: rtl/kbd_input_conditioner_pkg.sv
// Shared constants, keypad state encoding and helpers for the keypad/button
// conditioning front end.
package kbd_input_conditioner_pkg;

    localparam int NUM_KEYS    = 10;
    localparam int DIGIT_W     = 4;
    localparam int SYNC_STAGES = 2;

    // Keypad FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Released / safe values loaded during reset
    localparam logic [NUM_KEYS-1:0] KBD_REL  = '0;
    localparam logic                BTN_REL  = 1'b1;
    localparam logic                DOOR_REL = 1'b0;

    // Candidate events for one cycle, before priority resolution
    typedef struct packed {
        logic clear;
        logic stop;
        logic start;
        logic digit;
    } evt_t;

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    function automatic logic [DIGIT_W-1:0] key_index(input logic [NUM_KEYS-1:0] v);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (v[i]) idx = DIGIT_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/kbd_input_conditioner_debounce_filter.sv
// Synchroniser plus counter-based debounce for one input group (vector
// debounced as a whole). The value loaded into the last sync flop is the
// current sample; the last flop holds the previous sample.
module debounce_filter
    import kbd_input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0,
    parameter int               DEBOUNCE_CYCLES = 3,
    parameter int               CNT_W           = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [CNT_W-1:0]                  cnt;
    logic [WIDTH-1:0]                  sample;
    logic [WIDTH-1:0]                  prev;

    assign sample = sync_q[SYNC_STAGES-2];
    assign prev   = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain, index 0 is the newest
    always_ff @(posedge clk) begin
        if (!resetn) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // Count stable samples that differ from the debounced value; commit at the limit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            dout <= RESET_VAL;
        end else if (sample != prev || sample == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dout <= sample;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/kbd_input_conditioner.sv
// Keypad/button front end: debounced inputs become one-cycle event strobes
// with clear > stop > start > digit priority, plus a debounced door level.
module kbd_input_conditioner
    import kbd_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] kbd,
    input  logic                startn,
    input  logic                stopn,
    input  logic                clearn,
    input  logic                door_closed,
    output logic [DIGIT_W-1:0]  digit,
    output logic                digit_valid,
    output logic                start_pulse,
    output logic                stop_pulse,
    output logic                clear_pulse,
    output logic                door_closed_db,
    output logic                key_err
);

    logic [NUM_KEYS-1:0] kv;
    logic [2:0]          btn_raw;   // {clear, stop, start}, active-low
    logic [2:0]          btn_db;
    logic [2:0]          btn_prev;
    logic [2:0]          fall;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                key_ev;
    logic                kv_multi;
    evt_t                ev;

    assign btn_raw = {clearn, stopn, startn};

    debounce_filter #(
        .WIDTH(NUM_KEYS), .RESET_VAL(KBD_REL),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_kbd (.clk(clk), .resetn(resetn), .din(kbd), .dout(kv));

    for (genvar g = 0; g < 3; g++) begin : g_btn
        debounce_filter #(
            .WIDTH(1), .RESET_VAL(BTN_REL),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
        ) u_btn (.clk(clk), .resetn(resetn), .din(btn_raw[g]), .dout(btn_db[g]));
    end

    debounce_filter #(
        .WIDTH(1), .RESET_VAL(DOOR_REL),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_door (.clk(clk), .resetn(resetn), .din(door_closed), .dout(door_closed_db));

    assign kv_multi = (kv != '0) && !is_onehot(kv);
    assign fall     = btn_prev & ~btn_db;

    // Keypad FSM: one event per press, multi-hot locks out until full release
    always_comb begin
        state_nxt = state;
        key_ev    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_onehot(kv)) begin
                    state_nxt = ST_HELD;
                    key_ev    = 1'b1;
                end else if (kv_multi) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_HELD: begin
                if (kv == '0)    state_nxt = ST_IDLE;
                else if (kv_multi) state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (kv == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Priority resolution; start is gated by the door and dropped, never held over
    always_comb begin
        ev.clear = fall[2];
        ev.stop  = fall[1] & ~fall[2];
        ev.start = fall[0] & door_closed_db & ~fall[2] & ~fall[1];
        ev.digit = key_ev & ~fall[2] & ~fall[1] & ~(fall[0] & door_closed_db);
    end

    // Registered strobes, digit capture, FSM state and button history
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            btn_prev    <= {3{BTN_REL}};
            digit       <= '0;
            digit_valid <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            btn_prev    <= btn_db;
            digit_valid <= ev.digit;
            start_pulse <= ev.start;
            stop_pulse  <= ev.stop;
            clear_pulse <= ev.clear;
            key_err     <= (state_nxt == ST_LOCKED);
            if (ev.digit) digit <= key_index(kv);
        end
    end

endmodule

// File: tb/tb_kbd_input_conditioner.sv
// Bench for kbd_input_conditioner: directed scenarios followed by random
// traffic, every cycle compared against a window-based reference model.
module tb_kbd_input_conditioner;

    localparam int D = 3;
    localparam logic [13:0] REL = {1'b0, 1'b1, 1'b1, 1'b1, 10'b0};
    localparam int S_IDLE = 0, S_HELD = 1, S_LOCKED = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] kbd = '0;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b0;
    logic [3:0] digit;
    logic       digit_valid, start_pulse, stop_pulse, clear_pulse, door_closed_db, key_err;

    kbd_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .kbd(kbd), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed), .digit(digit),
        .digit_valid(digit_valid), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .clear_pulse(clear_pulse), .door_closed_db(door_closed_db), .key_err(key_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, dv_n = 0, tp_n = 0, sp_n = 0, cp_n = 0, last_dv = 0, t0 = 0;

    // reference model state: word layout {door, clear, stop, start, kbd[9:0]}
    logic [13:0] hist[$];
    logic [13:0] m_db = REL, m_prev = REL;
    int          m_state = S_IDLE;
    logic [3:0]  m_digit = '0;
    logic        m_dv = 0, m_tp = 0, m_sp = 0, m_cp = 0, m_ke = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] gmask(input int g);
        case (g)
            0:       return 14'h03FF;
            1:       return 14'h0400;
            2:       return 14'h0800;
            3:       return 14'h1000;
            default: return 14'h2000;
        endcase
    endfunction

    // One clock edge of the reference, x = raw inputs present at that edge
    task automatic model_edge(input logic [13:0] x, input logic rs);
        logic [9:0] kv;
        logic [2:0] fall;
        logic       door, clr, stp, sta, ev;
        int         nst, ones;
        if (!rs) begin
            m_db = REL; m_prev = REL; m_state = S_IDLE; m_digit = '0;
            m_dv = 0; m_tp = 0; m_sp = 0; m_cp = 0; m_ke = 0;
            hist.delete();
            for (int i = 0; i <= D; i++) hist.push_back(REL);
            return;
        end
        kv   = m_db[9:0];
        door = m_db[13];
        ones = $countones(kv);
        nst  = m_state;
        ev   = 0;
        if (m_state == S_IDLE) begin
            if (ones == 1) begin nst = S_HELD; ev = 1; end
            else if (ones > 1) nst = S_LOCKED;
        end else if (m_state == S_HELD) begin
            if (ones == 0) nst = S_IDLE;
            else if (ones > 1) nst = S_LOCKED;
        end else if (ones == 0) begin
            nst = S_IDLE;
        end
        fall = m_prev[12:10] & ~m_db[12:10];
        clr  = fall[2];
        stp  = fall[1] && !clr;
        sta  = fall[0] && door && !clr && !stp;
        m_cp = clr; m_sp = stp; m_tp = sta;
        m_dv = ev && !clr && !stp && !sta;
        if (m_dv) m_digit = 4'($clog2(kv));
        m_ke    = (nst == S_LOCKED);
        m_state = nst;
        m_prev  = m_db;
        // a group commits once its last D+1 samples agree on a new value
        for (int g = 0; g < 5; g++) begin
            logic [13:0] msk, v;
            logic        same;
            msk  = gmask(g);
            v    = hist[0] & msk;
            same = 1;
            foreach (hist[i]) if ((hist[i] & msk) != v) same = 0;
            if (same && v != (m_db & msk)) m_db = (m_db & ~msk) | v;
        end
        hist.push_back(x);
        void'(hist.pop_front());
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            logic [13:0] x;
            logic        rs;
            x  = {door_closed, clearn, stopn, startn, kbd};
            rs = resetn;
            @(posedge clk);
            model_edge(x, rs);
            #1;
            cyc++;
            chk("digit_valid", 16'(digit_valid), 16'(m_dv));
            chk("digit", 16'(digit), 16'(m_digit));
            chk("start_pulse", 16'(start_pulse), 16'(m_tp));
            chk("stop_pulse", 16'(stop_pulse), 16'(m_sp));
            chk("clear_pulse", 16'(clear_pulse), 16'(m_cp));
            chk("door_closed_db", 16'(door_closed_db), 16'(m_db[13]));
            chk("key_err", 16'(key_err), 16'(m_ke));
            if (digit_valid === 1'b1) begin dv_n++; last_dv = cyc; end
            if (start_pulse === 1'b1) tp_n++;
            if (stop_pulse === 1'b1) sp_n++;
            if (clear_pulse === 1'b1) cp_n++;
        end
    endtask

    task automatic chk_reset_zero(input string tag);
        chk({tag, "_outs"}, 16'({digit, digit_valid, start_pulse, stop_pulse,
                                 clear_pulse, door_closed_db, key_err}), 16'h0);
    endtask

    task automatic clr_counts();
        dv_n = 0; tp_n = 0; sp_n = 0; cp_n = 0; last_dv = 0;
    endtask

    initial begin
        // reset
        resetn = 0;
        tick(3);
        chk_reset_zero("reset");
        resetn = 1;
        tick(5);
        clr_counts();

        // single key 1, held then released
        kbd = 10'b0000000010;
        t0 = cyc;
        tick(20);
        chk("t1_dv_count", 16'(dv_n), 16'd1);
        chk("t1_latency", 16'(last_dv - t0), 16'd6);
        chk("t1_digit", 16'(digit), 16'd1);
        kbd = '0;
        tick(20);
        chk("t1_release_dv_count", 16'(dv_n), 16'd1);

        // short glitch on key 5
        clr_counts();
        kbd = 10'b0000100000;
        tick(2);
        kbd = '0;
        tick(15);
        chk("t2_dv_count", 16'(dv_n), 16'd0);
        chk("t2_digit", 16'(digit), 16'd1);

        // two keys together lock out, then key 9 alone
        clr_counts();
        kbd = 10'b0000100100;
        tick(10);
        chk("t3_key_err_held", 16'(key_err), 16'd1);
        tick(10);
        chk("t3_dv_locked", 16'(dv_n), 16'd0);
        kbd = '0;
        tick(15);
        chk("t3_key_err_rel", 16'(key_err), 16'd0);
        kbd = 10'b1000000000;
        tick(15);
        chk("t3_dv_count", 16'(dv_n), 16'd1);
        chk("t3_digit", 16'(digit), 16'd9);
        kbd = '0;
        tick(15);

        // start with door closed, then open; stop regardless of door
        clr_counts();
        door_closed = 1;
        tick(10);
        chk("t4_door_db", 16'(door_closed_db), 16'd1);
        startn = 0; tick(20); startn = 1; tick(10);
        chk("t4_start_closed", 16'(tp_n), 16'd1);
        clr_counts();
        door_closed = 0;
        tick(10);
        startn = 0; tick(20); startn = 1; tick(10);
        chk("t4_start_open", 16'(tp_n), 16'd0);
        stopn = 0; tick(20); stopn = 1; tick(10);
        chk("t4_stop_open", 16'(sp_n), 16'd1);

        // simultaneous clear/stop/start
        clr_counts();
        door_closed = 1;
        tick(10);
        clearn = 0; stopn = 0; startn = 0;
        tick(20);
        clearn = 1; stopn = 1; startn = 1;
        tick(10);
        chk("t5_clear", 16'(cp_n), 16'd1);
        chk("t5_stop", 16'(sp_n), 16'd0);
        chk("t5_start", 16'(tp_n), 16'd0);

        // reset in the middle of a key 3 debounce
        kbd = 10'b0000001000;
        tick(3);
        resetn = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_reset_zero("t6_in_reset");
        end
        resetn = 1;
        clr_counts();
        t0 = cyc;
        tick(20);
        chk("t6_dv_count", 16'(dv_n), 16'd1);
        chk("t6_latency", 16'(last_dv - t0), 16'd6);
        chk("t6_digit", 16'(digit), 16'd3);
        kbd = '0;
        tick(10);

        // random traffic
        for (int s = 0; s < 120; s++) begin
            int r, k;
            r = $urandom_range(0, 3);
            if (r == 0) kbd = '0;
            else if (r == 1) begin
                k = $urandom_range(0, 9);
                kbd = '0;
                kbd[k] = 1'b1;
            end else if (r == 2) kbd = 10'($urandom);
            startn      = ($urandom_range(0, 2) != 0);
            stopn       = ($urandom_range(0, 3) != 0);
            clearn      = ($urandom_range(0, 3) != 0);
            door_closed = ($urandom_range(0, 3) != 0);
            resetn      = ($urandom_range(0, 19) != 0);
            tick($urandom_range(1, 8));
        end
        resetn = 1;
        kbd = '0; startn = 1; stopn = 1; clearn = 1; door_closed = 0;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_input_conditioner.md
Name: kbd_input_conditioner

Overview:
Front-end stage feeding the microwave controller. It synchronises and debounces the raw 10-key keypad, the start/stop/clear buttons and the door switch. It converts them into single-cycle, clean event strobes (digit entry, start, stop, clear) and a debounced door level, which the controller consumes directly. It replaces the raw kbd/startn/stopn/clearn/door_closed connections with glitch-free, one-event-per-press signals.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive identical synchronised samples required before a debounced value changes (legal range 1..255)
CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
kbd  input  10  raw keypad, bit i high = key i pressed
startn  input  1  raw start button, active-low
stopn  input  1  raw stop button, active-low
clearn  input  1  raw clear button, active-low
door_closed  input  1  raw door switch, 1 = closed
digit  output  4  binary value of last accepted key (0..9), held until next accepted key
digit_valid  output  1  one-cycle strobe when a new key is accepted
start_pulse  output  1  one-cycle strobe per start press
stop_pulse  output  1  one-cycle strobe per stop press
clear_pulse  output  1  one-cycle strobe per clear press
door_closed_db  output  1  debounced door level
key_err  output  1  high while the debounced keypad is multi-hot

Behaviour:
- Reset: one clock and one reset, with reset synchronous and active-low (clk, resetn); sampled only on the rising edge of clk.
- While resetn=0:
  - All outputs are 0.
  - Sync/debounced registers are loaded with released values: kbd=0, buttons=1, door=0, so the door reads as open (safe).
  - Counters are 0 and the keypad FSM is IDLE.
- Synchroniser: 2-flop per input bit.
- Debounce, applied to each group: kbd as one 10-bit vector, each button, and the door.
  - The counter clears when the synchronised sample differs from the previous sample or equals the debounced value.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES, the debounced value takes the sample and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES samples is fully filtered.
- Latency: an input change first sampled at edge N updates the debounced value at edge N+1+DEBOUNCE_CYCLES. The corresponding strobe is high for exactly the cycle after edge N+2+DEBOUNCE_CYCLES.
- Keypad FSM, running on the debounced vector kv:
  - IDLE: kv=0. If kv becomes one-hot, go to HELD, set digit=index and pulse digit_valid. If kv becomes multi-hot, go to LOCKED.
  - HELD: if kv=0, go to IDLE. If a second key is added, go to LOCKED with no event and digit unchanged.
  - LOCKED: key_err=1. If kv=0, go to IDLE. No events are emitted while LOCKED.
  - Only one digit_valid per press; key release produces no event.
- Buttons: a strobe is emitted on the debounced high-to-low transition only. Holding a button produces no repeat strobes.
- start_pulse is suppressed, not deferred, if door_closed_db=0 in that cycle.
- door_closed_db is a level output with no strobe.
- Simultaneous events in the same cycle follow priority clear > stop > start > digit.
  - Lower-priority strobes in that cycle are dropped, not queued.
  - When digit_valid is dropped, digit is also not updated.
- Reset mid-operation: outputs clear at the first reset edge. After release, an input still held is treated as a fresh press and yields exactly one strobe at the normal latency.
- All strobes are registered outputs, with no combinational path from inputs.

Decomposition:
- Shared package contents:
  - NUM_KEYS=10
  - DIGIT_W=4
  - SYNC_STAGES=2
  - keypad FSM state encoding (IDLE, HELD, LOCKED)
  - release values (KBD_REL=0, BTN_REL=1, DOOR_REL=0)
- Sub-module: debounce_filter, parameterised by WIDTH, RESET_VAL and DEBOUNCE_CYCLES. It contains the synchroniser, counter and debounced register, and is instantiated five times (kbd W=10, startn, stopn, clearn, door_closed).
- Top level holds the keypad FSM, one-hot to binary encoder, edge detectors, door gating and priority logic.

Test Plan:
1. DEBOUNCE_CYCLES=3. Reset, then kbd=10'b0000000010 for 20 cycles, then 0 -> exactly one digit_valid, 6 cycles after change, with digit=1; no event on release.
2. kbd bit 5 high for 2 cycles only -> no digit_valid; digit keeps its previous value.
3. kbd=10'b0000100100 held, then released, then kbd=10'b1000000000 -> key_err=1 while held with no strobe; key_err=0 after release; one digit_valid with digit=9.
4. door_closed=1, startn low 20 cycles -> one start_pulse. Repeat with door_closed=0 -> no start_pulse. stopn low -> one stop_pulse regardless of door.
5. clearn and stopn and startn low on the same edge (door closed) -> clear_pulse only; stop_pulse and start_pulse never asserted for that press.
6. Press key 3, assert resetn=0 mid-debounce for 4 cycles, release reset with key still held -> outputs 0 during reset; then exactly one digit_valid with digit=3 at the normal latency after reset release.
